// File: rtl/dds_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dds_ctrl_pkg
// Shared definitions for the DDS key controller:
//   - debounce FSM state encoding (IDLE, PRESS_DB, HELD, REL_DB)
//   - default frequency / duty step constants and the tuning-word ceiling
//   - saturating arithmetic helpers used by the configuration registers
// -----------------------------------------------------------------------------
package dds_ctrl_pkg;

  // Debounce FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  // Default configuration constants
  localparam logic [31:0] DEF_BASE_WORD   = 32'd1717991;
  localparam logic [31:0] DEF_STEP_COARSE = 32'd858990;
  localparam logic [31:0] DEF_STEP_FINE   = 32'd86;
  localparam logic [31:0] WORD_MAX        = 32'h7FFF_FFFF;
  localparam logic [11:0] DEF_DUTY_STEP   = 12'd16;
  localparam logic [11:0] DUTY_MAX        = 12'd4095;
  localparam logic [11:0] DUTY_RESET      = 12'd2048;

  // Tuning-word add, computed in 33 bits and clamped to lim
  function automatic logic [31:0] sat_add_word(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, lim}) return lim;
    return s[31:0];
  endfunction

  // Duty add, clamped to 4095
  function automatic logic [11:0] sat_add_duty(input logic [11:0] a,
                                               input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[12]) return DUTY_MAX;
    return s[11:0];
  endfunction

  // Duty subtract, clamped to 0
  function automatic logic [11:0] sat_sub_duty(input logic [11:0] a,
                                               input logic [11:0] b);
    if (a < b) return '0;
    return a - b;
  endfunction

endpackage

// File: rtl/dds_key_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One push-button channel: 2-flop synchronizer, 4-state debounce FSM and,
// when DDS_KEY_REPEAT_EN is defined, hold/auto-repeat counters.
//
// Ports:
//   clk      in   sole clock
//   rst_n    in   synchronous active-low reset
//   i_key_n  in   raw asynchronous button, active-low
//   o_press  out  one-cycle press pulse (entry to HELD, plus repeats)
//
// Parameters:
//   DB_CNT   debounce length in cycles
//   HOLD_CNT cycles in HELD before the first repeat pulse
//   RPT_CNT  repeat period in cycles
//   REPEAT   1 = this channel auto-repeats (only with DDS_KEY_REPEAT_EN)
// -----------------------------------------------------------------------------
module key_debounce
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned DB_CNT   = 1000000,
  parameter int unsigned HOLD_CNT = 25000000,
  parameter int unsigned RPT_CNT  = 5000000,
  parameter int unsigned REPEAT   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  if (DB_CNT < 2 || HOLD_CNT < 1 || RPT_CNT < 1 || REPEAT > 1) begin : g_param_check
    $error("key_debounce: illegal parameter set");
  end

  localparam int unsigned CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  logic [1:0]    r_sync;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          w_key_n;

  assign w_key_n = r_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync  <= '1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_key_n) r_state <= ST_PRESS_DB;
        end
        ST_PRESS_DB: begin
          if (w_key_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          r_cnt <= '0;
          if (w_key_n) r_state <= ST_REL_DB;
        end
        ST_REL_DB: begin
          if (!w_key_n) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DDS_KEY_REPEAT_EN
  localparam int unsigned HW = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
  localparam int unsigned RW = (RPT_CNT > 1) ? $clog2(RPT_CNT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_CNT - 1);

  logic [HW-1:0] r_hold;
  logic [RW-1:0] r_rpt;
  logic          r_rep_phase;
  logic          r_rpt_pulse;
  logic          w_stay_held;

  // Counting only while the FSM remains in HELD this cycle; any exit
  // (or re-entry from REL_DB) restarts the hold interval.
  assign w_stay_held = (r_state == ST_HELD) && !w_key_n && (REPEAT != 0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_rpt       <= '0;
      r_rep_phase <= 1'b0;
      r_rpt_pulse <= 1'b0;
    end else begin
      r_rpt_pulse <= 1'b0;
      if (!w_stay_held) begin
        r_hold      <= '0;
        r_rpt       <= '0;
        r_rep_phase <= 1'b0;
      end else if (!r_rep_phase) begin
        if (r_hold == HOLD_LAST) begin
          r_rpt_pulse <= 1'b1;
          r_rep_phase <= 1'b1;
          r_rpt       <= '0;
        end else begin
          r_hold <= r_hold + 1'b1;
        end
      end else begin
        if (r_rpt == RPT_LAST) begin
          r_rpt_pulse <= 1'b1;
          r_rpt       <= '0;
        end else begin
          r_rpt <= r_rpt + 1'b1;
        end
      end
    end
  end

  assign o_press = r_press | r_rpt_pulse;
`else
  assign o_press = r_press;
`endif

endmodule

// File: rtl/dds_key_ctrl.sv
// -----------------------------------------------------------------------------
// dds_key_ctrl
// Five debounced buttons adjust a DDS configuration: tuning word (coarse and
// fine steps, clamped at WORD_MAX), square-wave duty threshold (clamped to
// 0..4095) and sine/square selection. cfg_update pulses for one cycle,
// together with the new register values, whenever any output changed.
// Optional auto-repeat on held keys (except wave): define DDS_KEY_REPEAT_EN.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   key_coarse_n, key_fine_n   frequency keys (raw, active-low)
//   key_duty_inc_n/_dec_n      duty keys (raw, active-low)
//   key_wave_n                 waveform toggle key (raw, active-low)
//   fre_word[31:0]             DDS tuning word
//   duty_cycle[11:0]           square-wave threshold
//   wave_flag                  0 = sine, 1 = square
//   cfg_update                 one-cycle change pulse
// -----------------------------------------------------------------------------
module dds_key_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned DB_CNT      = 1000000,
  parameter logic [31:0] BASE_WORD   = DEF_BASE_WORD,
  parameter logic [31:0] STEP_COARSE = DEF_STEP_COARSE,
  parameter logic [31:0] STEP_FINE   = DEF_STEP_FINE,
  parameter logic [31:0] WORD_MAX    = dds_ctrl_pkg::WORD_MAX,
  parameter logic [11:0] DUTY_STEP   = DEF_DUTY_STEP,
  parameter int unsigned HOLD_CNT    = 25000000,
  parameter int unsigned RPT_CNT     = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_coarse_n,
  input  logic        key_fine_n,
  input  logic        key_duty_inc_n,
  input  logic        key_duty_dec_n,
  input  logic        key_wave_n,
  output logic [31:0] fre_word,
  output logic [11:0] duty_cycle,
  output logic        wave_flag,
  output logic        cfg_update
);

  logic w_p_coarse, w_p_fine, w_p_inc, w_p_dec, w_p_wave;

  key_debounce #(.DB_CNT(DB_CNT), .HOLD_CNT(HOLD_CNT), .RPT_CNT(RPT_CNT), .REPEAT(1))
    u_key_coarse (.clk(clk), .rst_n(rst_n), .i_key_n(key_coarse_n), .o_press(w_p_coarse));
  key_debounce #(.DB_CNT(DB_CNT), .HOLD_CNT(HOLD_CNT), .RPT_CNT(RPT_CNT), .REPEAT(1))
    u_key_fine (.clk(clk), .rst_n(rst_n), .i_key_n(key_fine_n), .o_press(w_p_fine));
  key_debounce #(.DB_CNT(DB_CNT), .HOLD_CNT(HOLD_CNT), .RPT_CNT(RPT_CNT), .REPEAT(1))
    u_key_inc (.clk(clk), .rst_n(rst_n), .i_key_n(key_duty_inc_n), .o_press(w_p_inc));
  key_debounce #(.DB_CNT(DB_CNT), .HOLD_CNT(HOLD_CNT), .RPT_CNT(RPT_CNT), .REPEAT(1))
    u_key_dec (.clk(clk), .rst_n(rst_n), .i_key_n(key_duty_dec_n), .o_press(w_p_dec));
  key_debounce #(.DB_CNT(DB_CNT), .HOLD_CNT(HOLD_CNT), .RPT_CNT(RPT_CNT), .REPEAT(0))
    u_key_wave (.clk(clk), .rst_n(rst_n), .i_key_n(key_wave_n), .o_press(w_p_wave));

  logic [31:0] r_fre_word;
  logic [11:0] r_duty;
  logic        r_wave;
  logic        r_cfg_update;

  logic [31:0] w_fre_next;
  logic [11:0] w_duty_next;
  logic        w_wave_next;
  logic        w_changed;

  // Coarse beats fine, inc beats dec; frequency and duty apply independently.
  always_comb begin
    w_fre_next  = r_fre_word;
    w_duty_next = r_duty;
    w_wave_next = r_wave ^ w_p_wave;
    if (w_p_coarse)    w_fre_next = sat_add_word(r_fre_word, STEP_COARSE, WORD_MAX);
    else if (w_p_fine) w_fre_next = sat_add_word(r_fre_word, STEP_FINE, WORD_MAX);
    if (w_p_inc)       w_duty_next = sat_add_duty(r_duty, DUTY_STEP);
    else if (w_p_dec)  w_duty_next = sat_sub_duty(r_duty, DUTY_STEP);
    // Clamped presses leave values unchanged and therefore raise no update.
    w_changed = (w_fre_next != r_fre_word) || (w_duty_next != r_duty) ||
                (w_wave_next != r_wave);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fre_word   <= BASE_WORD;
      r_duty       <= DUTY_RESET;
      r_wave       <= 1'b0;
      r_cfg_update <= 1'b0;
    end else begin
      r_fre_word   <= w_fre_next;
      r_duty       <= w_duty_next;
      r_wave       <= w_wave_next;
      r_cfg_update <= w_changed;
    end
  end

  assign fre_word   = r_fre_word;
  assign duty_cycle = r_duty;
  assign wave_flag  = r_wave;
  assign cfg_update = r_cfg_update;

endmodule

// File: tb/tb_dds_key_ctrl.sv
module tb_dds_key_ctrl;

  localparam longint FMAX   = 64'h7FFF_FFFF;
  localparam longint FBASE  = 1717991;
  localparam longint FCOARSE = 858990;
  localparam longint FFINE  = 86;

  localparam logic [4:0] M_COARSE = 5'b00001;
  localparam logic [4:0] M_FINE   = 5'b00010;
  localparam logic [4:0] M_INC    = 5'b00100;
  localparam logic [4:0] M_DEC    = 5'b01000;
  localparam logic [4:0] M_WAVE   = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  keys_n = '1;
  logic [31:0] fre_word;
  logic [11:0] duty_cycle;
  logic        wave_flag;
  logic        cfg_update;

  always #5 clk = ~clk;

  dds_key_ctrl #(
    .DB_CNT(4),
    .HOLD_CNT(20),
    .RPT_CNT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_coarse_n(keys_n[0]),
    .key_fine_n(keys_n[1]),
    .key_duty_inc_n(keys_n[2]),
    .key_duty_dec_n(keys_n[3]),
    .key_wave_n(keys_n[4]),
    .fre_word(fre_word),
    .duty_cycle(duty_cycle),
    .wave_flag(wave_flag),
    .cfg_update(cfg_update)
  );

  typedef struct packed {
    logic [31:0] fre;
    logic [11:0] duty;
    logic        wave;
  } exp_t;

  exp_t   q[$];
  int     total = 0;
  int     bad = 0;
  int     pops = 0;
  longint m_fre = FBASE;
  int     m_duty = 2048;
  bit     m_wave = 1'b0;

  // Reference model: one press event with the given key set
  task automatic model_press(input logic [4:0] m);
    longint f;
    int     d;
    bit     w;
    exp_t   e;
    f = m_fre;
    d = m_duty;
    w = m_wave;
    if (m[0])      f = f + FCOARSE;
    else if (m[1]) f = f + FFINE;
    if (f > FMAX) f = FMAX;
    if (m[2])      d = d + 16;
    else if (m[3]) d = d - 16;
    if (d > 4095) d = 4095;
    if (d < 0)    d = 0;
    if (m[4]) w = !w;
    if (f != m_fre || d != m_duty || w != m_wave) begin
      e.fre  = 32'(f);
      e.duty = 12'(d);
      e.wave = w;
      q.push_back(e);
    end
    m_fre  = f;
    m_duty = d;
    m_wave = w;
  endtask

  task automatic model_reset();
    m_fre  = FBASE;
    m_duty = 2048;
    m_wave = 1'b0;
    q.delete();
  endtask

  // Monitor: every cfg_update must match the oldest expected configuration
  always @(negedge clk) begin
    if (!rst_n) begin
      total++;
      if (cfg_update !== 1'b0) begin
        bad++;
        $display("FAIL cfg_in_reset: got %b want 0", cfg_update);
      end
    end else if (cfg_update === 1'b1) begin
      total++;
      pops++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_cfg: fre=%0d duty=%0d wave=%0d with nothing expected",
                 fre_word, duty_cycle, wave_flag);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (fre_word !== e.fre || duty_cycle !== e.duty || wave_flag !== e.wave) begin
          bad++;
          $display("FAIL cfg_value: got fre=%0d duty=%0d wave=%0d want fre=%0d duty=%0d wave=%0d",
                   fre_word, duty_cycle, wave_flag, e.fre, e.duty, e.wave);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    chk({name, "_fre"}, fre_word, 32'(m_fre));
    chk({name, "_duty"}, {20'd0, duty_cycle}, 32'(m_duty));
    chk({name, "_wave"}, {31'd0, wave_flag}, {31'd0, m_wave});
  endtask

  task automatic wait_drain(input int unsigned maxcyc);
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < maxcyc) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d expected updates never seen", q.size());
      q.delete();
    end
  endtask

  task automatic hold_keys(input logic [4:0] m, input int unsigned low, input int unsigned high);
    keys_n = ~m;
    repeat (low) @(negedge clk);
    keys_n = '1;
    repeat (high) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] m);
    model_press(m);
    hold_keys(m, 9, 10);
  endtask

  task automatic do_reset(input int unsigned cyc);
    rst_n = 1'b0;
    repeat (cyc) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  m;
    longint      f0;
    int          p0;
    int unsigned n;

    // Reset then idle
    repeat (5) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_model("reset");
    chk("reset_fre_abs", fre_word, 32'd1717991);

    // Bounce: low 2, high 1, low 10 -> one coarse step
    model_press(M_COARSE);
    hold_keys(M_COARSE, 2, 1);
    hold_keys(M_COARSE, 10, 12);
    wait_drain(40);
    chk("bounce_fre", fre_word, 32'd2576981);

    // Simultaneous coarse+fine and inc+dec
    press(M_COARSE | M_FINE | M_INC | M_DEC);
    wait_drain(40);
    chk("simul_fre", fre_word, 32'd3435971);
    chk("simul_duty", {20'd0, duty_cycle}, 32'd2064);

    // Random presses and short glitches
    for (int i = 0; i < 40; i++) begin
      m = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 3) == 0) begin
        hold_keys(m, $urandom_range(1, 3), 8);
      end else begin
        model_press(m);
        hold_keys(m, $urandom_range(9, 14), $urandom_range(10, 14));
      end
    end
    wait_drain(40);
    check_model("random");

    // Duty clamp at 4095, then one decrement
    for (int i = 0; i < 300; i++) press(M_INC);
    wait_drain(40);
    chk("clamp_top", {20'd0, duty_cycle}, 32'd4095);
    press(M_DEC);
    wait_drain(40);
    chk("clamp_dec", {20'd0, duty_cycle}, 32'd4079);

    // Long hold of fine: repeats only when auto-repeat is built in
    f0 = m_fre;
    p0 = pops;
    model_press(M_FINE);
`ifdef DDS_KEY_REPEAT_EN
    for (int i = 0; i < 3; i++) model_press(M_FINE);
`endif
    keys_n = ~M_FINE;
    n = 0;
    while (pops == p0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pops == p0) begin
      bad++;
      $display("FAIL hold_first_press: no update within %0d cycles", n);
    end
    repeat (38) @(negedge clk);
    keys_n = '1;
    wait_drain(80);
    repeat (20) @(negedge clk);
`ifdef DDS_KEY_REPEAT_EN
    chk("hold_fre", fre_word, 32'(f0 + 344));
`else
    chk("hold_fre", fre_word, 32'(f0 + 86));
`endif

    // Reset while held: key released during reset -> defaults, no pulses
    model_press(M_INC);
    keys_n = ~M_INC;
    repeat (20) @(negedge clk);
    wait_drain(20);
    do_reset(3);
    keys_n = '1;
    repeat (30) @(negedge clk);
    check_model("rst_held");

    // Reset mid-debounce discards the pending press
    keys_n = ~M_COARSE;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    keys_n = '1;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_model("rst_mid_db");

    // Key held through reset release: one fresh press after debounce
    model_press(M_WAVE);
    keys_n = ~M_WAVE;
    repeat (20) @(negedge clk);
    wait_drain(20);
    do_reset(3);
    model_press(M_WAVE);
    repeat (12) @(negedge clk);
    keys_n = '1;
    wait_drain(40);
    repeat (10) @(negedge clk);
    check_model("rst_through");

    // Ceiling: coarse presses until clamped at WORD_MAX, no wrap
    n = 0;
    while (m_fre < FMAX && n < 3000) begin
      model_press(M_COARSE);
      hold_keys(M_COARSE, 9, 9);
      n++;
    end
    press(M_COARSE);
    press(M_FINE);
    wait_drain(40);
    chk("ceiling_fre", fre_word, 32'h7FFF_FFFF);
    check_model("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
